seg_scanner: RTL

Time-multiplexing scanner for the 8-digit 7-segment bank. It holds a 16-entry message buffer of 5-bit display codes and shows an 8-digit window of that buffer, either fixed or scrolling. Each refresh slot selects one digit, drives its one-hot enable, and presents that digit's code on `seg_code`. `seg_code` feeds the single-digit code-to-segment decoder, whose 8-bit segment pattern goes to the pins together with `digit_en`.

---
 rtl/seg_scanner.sv | 88 ++++++++
 1 files changed

// File: rtl/seg_scanner.sv
// Time-multiplexed 8-digit scanner over a 16-entry message buffer, with an
// optional scrolling window and a registered pulse when the window wraps.
module seg_scanner #(
    parameter int SCAN_DIV   = 100000,
    parameter int SCROLL_DIV = 50000000,
    parameter int MSG_LEN    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       scroll_en,
    output logic [4:0] seg_code,
    output logic [7:0] digit_en,
    output logic       wrap_pulse
);
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
    localparam logic [4:0]          BLANK       = 5'h1F;

    logic [4:0]          msg_reg [MSG_LEN];
    logic [MSG_LEN-1:0]  wr_sel;
    logic [SCAN_W-1:0]   scnt_reg;
    logic [2:0]          idx_reg;
    logic [SCROLL_W-1:0] rcnt_reg;
    logic [3:0]          offset_reg;
    logic [3:0]          rd_addr;
    logic                scan_last;
    logic                scroll_last;

    genvar gi;
    generate
        for (gi = 0; gi < MSG_LEN; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == 4'(gi));
        end
    endgenerate

    // Buffer is plain registers because every entry must reset to blank.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MSG_LEN; i++) begin
            if (rst) begin
                msg_reg[i] <= BLANK;
            end else if (wr_sel[i]) begin
                msg_reg[i] <= wr_data;
            end
        end
    end

    assign scan_last   = (scnt_reg == SCAN_LAST);
    assign scroll_last = (rcnt_reg == SCROLL_LAST);
    // Natural 4-bit wrap gives the circular window over the 16 slots.
    assign rd_addr     = offset_reg + {1'b0, idx_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_reg   <= '0;
            idx_reg    <= '0;
            rcnt_reg   <= '0;
            offset_reg <= '0;
            seg_code   <= BLANK;
            digit_en   <= 8'h01;
            wrap_pulse <= 1'b0;
        end else begin
            scnt_reg <= scan_last ? '0 : scnt_reg + 1'b1;
            if (scan_last) begin
                idx_reg <= idx_reg + 3'd1;
            end

            if (scroll_en) begin
                rcnt_reg <= scroll_last ? '0 : rcnt_reg + 1'b1;
                if (scroll_last) begin
                    offset_reg <= offset_reg + 4'd1;
                end
            end else begin
                rcnt_reg   <= '0;
                offset_reg <= '0;
            end

            // Only a genuine 15 -> 0 scroll step pulses; the scroll_en snap-back does not.
            wrap_pulse <= scroll_en && scroll_last && (offset_reg == 4'hF);
            seg_code   <= msg_reg[rd_addr];
            digit_en   <= 8'b1 << idx_reg;
        end
    end
endmodule
